// File: rtl/mem_ctl_sync.sv
// mem_ctl_sync: synchronous memory-access controller with 4-phase host, memory and consumer handshakes
module mem_ctl_sync #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic          din_ack,
  output logic          write,
  output logic          read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ack,
  output logic          busy,
  output logic          timeout_err,
  output logic [3:0]    state
);
  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    W_REQ   = 4'b0001,
    W_REL   = 4'b0011,
    R_REQ   = 4'b0111,
    R_OUT   = 4'b0101,
    R_DROP  = 4'b0100,
    R_REL   = 4'b1100,
    ACK     = 4'b1101,
    ACK_REL = 4'b1001,
    ERR     = 4'b1111
  } state_t;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  state_t st, st_n;
  logic [2:0] raw, syn;
  logic dv, md, da;
  logic [CW-1:0] cnt;
  logic watched, to;
  logic write_n, read_n, ack_n, dval_n, err_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n, dout_n;
  assign raw = {dout_ack, mem_done, din_valid};
  assign {da, md, dv} = syn;
  assign state = st;
  if (SYNC_STAGES == 0) begin : g_bypass
    assign syn = raw;
  end else begin : g_sync
    logic [2:0] sr [SYNC_STAGES];
    always_ff @(posedge clk) begin
      sr[0] <= rst ? 3'b0 : raw;
      for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= rst ? 3'b0 : sr[i-1];
    end
    assign syn = sr[SYNC_STAGES-1];
  end
  assign watched = st inside {W_REQ, W_REL, R_REQ, R_REL};
  assign to = TIMEOUT_CYCLES != 0 && watched && cnt == TMAX;
  always_comb begin
    st_n = st;
    write_n = write;
    read_n = read;
    ack_n = din_ack;
    dval_n = dout_valid;
    err_n = timeout_err;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    dout_n = dout;
    case (st)
      IDLE: if (dv) begin
        addr_n = addr;
        wdata_n = din;
        write_n = wen;
        read_n = !wen;
        st_n = wen ? W_REQ : R_REQ;
      end
      W_REQ: if (md) begin
        write_n = 1'b0;
        st_n = W_REL;
      end
      W_REL, R_REL, ERR: if (!md) begin
        ack_n = 1'b1;
        st_n = ACK;
      end
      R_REQ: if (md) begin
        dout_n = mem_rdata;
        dval_n = 1'b1;
        st_n = R_OUT;
      end
      R_OUT: if (da) begin
        dval_n = 1'b0;
        st_n = R_DROP;
      end
      R_DROP: if (!da) begin
        read_n = 1'b0;
        st_n = R_REL;
      end
      ACK: if (!dv) begin
        ack_n = 1'b0;
        st_n = ACK_REL;
      end
      default: st_n = IDLE;
    endcase
    if (to && st_n == st) begin
      write_n = 1'b0;
      read_n = 1'b0;
      dval_n = 1'b0;
      err_n = 1'b1;
      st_n = ERR;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      write <= 1'b0;
      read <= 1'b0;
      din_ack <= 1'b0;
      dout_valid <= 1'b0;
      timeout_err <= 1'b0;
      busy <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      dout <= '0;
      cnt <= '0;
    end else begin
      st <= st_n;
      write <= write_n;
      read <= read_n;
      din_ack <= ack_n;
      dout_valid <= dval_n;
      timeout_err <= err_n;
      busy <= st_n != IDLE;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      dout <= dout_n;
      cnt <= (st_n != st || !watched) ? '0 : cnt + 1'b1;
    end
  end
endmodule
